// File: rtl/uart_fifo_bridge.sv
// ============================================================================
// Module   : uart_fifo_bridge
// Purpose  : TX/RX byte FIFOs between host logic and the uart_transceiver core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_bridge_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty = (level == '0);
    assign full  = (level == DEPTH[DEPTH_LOG2:0]);
    assign head  = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_tx_push,
    input  logic [7:0]            host_tx_data,
    output logic                  host_tx_full,
    output logic [DEPTH_LOG2:0]   host_tx_level,
    input  logic                  host_rx_pop,
    output logic [7:0]            host_rx_data,
    output logic                  host_rx_empty,
    output logic [DEPTH_LOG2:0]   host_rx_level,
    output logic                  rx_overrun,
    output logic                  rx_frame_err,
    input  logic                  err_clear,
    output logic [7:0]            u_tx_data,
    output logic                  u_tx_wr,
    input  logic                  u_tx_busy,
    input  logic [7:0]            u_rx_data,
    input  logic                  u_rx_avail,
    input  logic                  u_rx_error,
    output logic                  u_rx_ack
);
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_ISSUE     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_ACK   = 2'd1,
        RX_GUARD = 2'd2
    } rx_state_t;

    tx_state_t tx_state;
    tx_state_t tx_state_next;
    rx_state_t rx_state;
    rx_state_t rx_state_next;

    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_pop;
    logic       tx_wr_next;
    logic [7:0] tx_data_next;

    logic       rx_full;
    logic       rx_push;
    logic       rx_room;
    logic       rx_ack_next;
    logic       overrun_set;
    logic       frame_set;

    uart_fifo_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host_tx_push),
        .push_data (host_tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (host_tx_full),
        .level     (host_tx_level)
    );

    uart_fifo_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (u_rx_data),
        .pop       (host_rx_pop),
        .head      (host_rx_data),
        .empty     (host_rx_empty),
        .full      (rx_full),
        .level     (host_rx_level)
    );

    // TX drain: one byte in flight, waits for busy to rise and fall again.
    always_comb begin
        tx_state_next = tx_state;
        tx_wr_next    = 1'b0;
        tx_data_next  = u_tx_data;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !u_tx_busy) begin
                    tx_data_next  = tx_head;
                    tx_wr_next    = 1'b1;
                    tx_pop        = 1'b1;
                    tx_state_next = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                tx_state_next = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (u_tx_busy) begin
                    tx_state_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!u_tx_busy) begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            u_tx_wr   <= 1'b0;
            u_tx_data <= 8'h00;
        end else begin
            tx_state  <= tx_state_next;
            u_tx_wr   <= tx_wr_next;
            u_tx_data <= tx_data_next;
        end
    end

    // A full RX FIFO still has room when the host pops in the same cycle.
    assign rx_room = !rx_full || host_rx_pop;

    always_comb begin
        rx_state_next = rx_state;
        rx_ack_next   = 1'b0;
        rx_push       = 1'b0;
        overrun_set   = 1'b0;
        frame_set     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (u_rx_avail) begin
                    rx_push       = rx_room;
                    overrun_set   = !rx_room;
                    rx_ack_next   = 1'b1;
                    rx_state_next = RX_ACK;
                end else if (u_rx_error) begin
                    frame_set     = 1'b1;
                    rx_ack_next   = 1'b1;
                    rx_state_next = RX_ACK;
                end
            end
            RX_ACK: begin
                rx_state_next = RX_GUARD;
            end
            RX_GUARD: begin
                rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            u_rx_ack <= 1'b0;
        end else begin
            rx_state <= rx_state_next;
            u_rx_ack <= rx_ack_next;
        end
    end

    // Clear wins over a set arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else if (err_clear) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                rx_overrun <= 1'b1;
            end
            if (frame_set) begin
                rx_frame_err <= 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
// ============================================================================
// Module   : tb_uart_fifo_bridge
// Purpose  : Randomized self-checking bench for uart_fifo_bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_fifo_bridge;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                reset;
    logic                host_tx_push;
    logic [7:0]          host_tx_data;
    logic                host_tx_full;
    logic [DEPTH_LOG2:0] host_tx_level;
    logic                host_rx_pop;
    logic [7:0]          host_rx_data;
    logic                host_rx_empty;
    logic [DEPTH_LOG2:0] host_rx_level;
    logic                rx_overrun;
    logic                rx_frame_err;
    logic                err_clear;
    logic [7:0]          u_tx_data;
    logic                u_tx_wr;
    logic                u_tx_busy;
    logic [7:0]          u_rx_data;
    logic                u_rx_avail;
    logic                u_rx_error;
    logic                u_rx_ack;

    uart_fifo_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_tx_push  (host_tx_push),
        .host_tx_data  (host_tx_data),
        .host_tx_full  (host_tx_full),
        .host_tx_level (host_tx_level),
        .host_rx_pop   (host_rx_pop),
        .host_rx_data  (host_rx_data),
        .host_rx_empty (host_rx_empty),
        .host_rx_level (host_rx_level),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err),
        .err_clear     (err_clear),
        .u_tx_data     (u_tx_data),
        .u_tx_wr       (u_tx_wr),
        .u_tx_busy     (u_tx_busy),
        .u_rx_data     (u_rx_data),
        .u_rx_avail    (u_rx_avail),
        .u_rx_error    (u_rx_error),
        .u_rx_ack      (u_rx_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte queues standing for FIFO contents plus flag state.
    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];
    logic [7:0] loop_q [$];
    logic       exp_ovr = 1'b0;
    logic       exp_frm = 1'b0;
    bit         loopback = 1'b0;
    bit         busy_hold = 1'b0;
    int         tx_count = 0;
    int         first_push_cyc = -1;
    int         first_wr_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural transceiver TX side: busy rises one cycle after tx_wr.
    initial begin
        logic [7:0] d;
        u_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_hold) begin
                u_tx_busy = 1'b1;
            end else if (u_tx_wr) begin
                check_eq("tx_wr_while_busy", 32'(u_tx_busy), 0);
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                check_eq("tx_expected_byte", 32'(tx_exp.size() > 0), 1);
                d = u_tx_data;
                if (tx_exp.size() > 0) check_eq("tx_data", 32'(d), 32'(tx_exp.pop_front()));
                if (loopback) loop_q.push_back(d);
                tx_count++;
                @(negedge clk);
                check_eq("tx_wr_width", 32'(u_tx_wr), 0);
                u_tx_busy = 1'b1;
                repeat ($urandom_range(2, 8)) @(negedge clk);
                u_tx_busy = 1'b0;
            end else begin
                u_tx_busy = 1'b0;
            end
        end
    end

    task automatic push_one(input logic [7:0] d);
        host_tx_push = 1'b1;
        host_tx_data = d;
        if (first_push_cyc < 0) first_push_cyc = cyc;
        if (tx_exp.size() < DEPTH) tx_exp.push_back(d);
        @(negedge clk);
        host_tx_push = 1'b0;
    endtask

    task automatic pop_one();
        check_eq("rx_not_empty", 32'(host_rx_empty), 0);
        check_eq("rx_data", 32'(host_rx_data), 32'(rx_exp[0]));
        host_rx_pop = 1'b1;
        @(negedge clk);
        host_rx_pop = 1'b0;
        void'(rx_exp.pop_front());
    endtask

    task automatic inject(input logic [7:0] d, input logic err, input logic clr);
        bit seen = 1'b0;
        int guard = 0;
        u_rx_data  = d;
        u_rx_avail = !err;
        u_rx_error = err;
        err_clear  = clr;
        if (!err) begin
            if (rx_exp.size() < DEPTH) rx_exp.push_back(d);
            else exp_ovr = 1'b1;
        end else begin
            exp_frm = 1'b1;
        end
        if (clr) begin
            exp_ovr = 1'b0;
            exp_frm = 1'b0;
        end
        while (!seen && guard < 8) begin
            @(negedge clk);
            err_clear = 1'b0;
            seen = u_rx_ack;
            guard++;
        end
        check_eq("rx_ack_seen", 32'(seen), 1);
        u_rx_avail = 1'b0;
        u_rx_error = 1'b0;
        @(negedge clk);
        check_eq("rx_ack_width", 32'(u_rx_ack), 0);
        @(negedge clk);
        check_eq("rx_level", 32'(host_rx_level), rx_exp.size());
        check_eq("rx_overrun", 32'(rx_overrun), 32'(exp_ovr));
        check_eq("rx_frame_err", 32'(rx_frame_err), 32'(exp_frm));
    endtask

    task automatic run_loopback(input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 3000) begin
            if (loop_q.size() > 0) begin
                inject(loop_q.pop_front(), 1'b0, 1'b0);
                got++;
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        check_eq("loopback_count", got, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        int base;
        logic [7:0] d;
        reset = 1'b1;
        host_tx_push = 1'b0; host_tx_data = 8'h00; host_rx_pop = 1'b0;
        err_clear = 1'b0; u_rx_data = 8'h00; u_rx_avail = 1'b0; u_rx_error = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_rx_empty", 32'(host_rx_empty), 1);
        check_eq("rst_tx_full", 32'(host_tx_full), 0);
        check_eq("rst_tx_data", 32'(u_tx_data), 0);
        repeat (10) @(negedge clk);
        check_eq("idle_rx_empty", 32'(host_rx_empty), 1);
        check_eq("idle_tx_level", 32'(host_tx_level), 0);
        check_eq("idle_rx_level", 32'(host_rx_level), 0);
        check_eq("idle_tx_wr", 32'(u_tx_wr), 0);
        check_eq("idle_rx_ack", 32'(u_rx_ack), 0);
        check_eq("idle_overrun", 32'(rx_overrun), 0);
        check_eq("idle_frame_err", 32'(rx_frame_err), 0);

        // Directed loopback of three bytes.
        loopback = 1'b1;
        push_one(8'h55);
        push_one(8'hA3);
        push_one(8'h0F);
        run_loopback(3);
        check_eq("tx_first_latency", first_wr_cyc - first_push_cyc, 2);
        check_eq("tx_count3", tx_count, 3);
        while (rx_exp.size() > 0) pop_one();
        check_eq("rx_level_drained", 32'(host_rx_level), 0);

        // Randomized loopback bursts.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                push_one(8'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            run_loopback(n);
            check_eq("rnd_tx_level", 32'(host_tx_level), 0);
            check_eq("rnd_rx_level", 32'(host_rx_level), rx_exp.size());
            while (rx_exp.size() > 0) pop_one();
        end
        loopback = 1'b0;

        // TX saturation while the transceiver is held busy.
        repeat (20) @(negedge clk);
        base = tx_count;
        busy_hold = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) push_one(8'($urandom));
        check_eq("tx_sat_level", 32'(host_tx_level), DEPTH);
        check_eq("tx_sat_full", 32'(host_tx_full), 1);
        busy_hold = 1'b0;
        guard = 0;
        while (tx_exp.size() > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (60) @(negedge clk);
        check_eq("tx_sat_sent", tx_count - base, DEPTH);
        check_eq("tx_sat_empty", 32'(host_tx_level), 0);
        check_eq("tx_sat_notfull", 32'(host_tx_full), 0);

        // RX overrun with no host pops.
        for (int i = 0; i < DEPTH + 1; i++) inject(8'($urandom), 1'b0, 1'b0);
        check_eq("ovr_level", 32'(host_rx_level), DEPTH);
        check_eq("ovr_flag", 32'(rx_overrun), 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_ovr = 1'b0;
        check_eq("ovr_cleared", 32'(rx_overrun), 0);

        // Capture coinciding with a pop on a full FIFO.
        d = 8'($urandom);
        check_eq("full_head", 32'(host_rx_data), 32'(rx_exp[0]));
        u_rx_data = d;
        u_rx_avail = 1'b1;
        host_rx_pop = 1'b1;
        @(negedge clk);
        host_rx_pop = 1'b0;
        check_eq("full_pop_ack", 32'(u_rx_ack), 1);
        u_rx_avail = 1'b0;
        void'(rx_exp.pop_front());
        rx_exp.push_back(d);
        repeat (2) @(negedge clk);
        check_eq("full_pop_level", 32'(host_rx_level), DEPTH);
        check_eq("full_pop_no_ovr", 32'(rx_overrun), 0);
        while (rx_exp.size() > 0) pop_one();

        // Framing errors, then clear colliding with a new set.
        inject(8'h00, 1'b1, 1'b0);
        check_eq("frm_level", 32'(host_rx_level), 0);
        inject(8'h00, 1'b1, 1'b1);

        // Reset in the middle of a transmission.
        inject(8'($urandom), 1'b0, 1'b0);
        inject(8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_one(8'($urandom));
        guard = 0;
        while (!u_tx_wr && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("mid_tx_wr_seen", 32'(u_tx_wr), 1);
        reset = 1'b1;
        tx_exp.delete();
        rx_exp.delete();
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_tx_wr", 32'(u_tx_wr), 0);
        check_eq("mid_rst_tx_level", 32'(host_tx_level), 0);
        check_eq("mid_rst_rx_empty", 32'(host_rx_empty), 1);
        check_eq("mid_rst_rx_level", 32'(host_rx_level), 0);
        repeat (20) @(negedge clk);
        check_eq("post_rst_tx_level", 32'(host_tx_level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Buffering stage between the host/bus logic and the uart_transceiver core.
- A TX FIFO accepts host bytes and drains them into the transceiver's tx_data/tx_wr/tx_busy handshake.
- An RX FIFO captures bytes from the transceiver's rx_data/rx_avail/rx_error/rx_ack handshake and holds them for the host.
- Records sticky overrun and framing-error flags.

Parameters:
- DEPTH_LOG2, 4: log2 of entries per FIFO (16 entries). Legal range 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- host_tx_push  in  1  write host_tx_data into TX FIFO
- host_tx_data  in  8  byte to transmit
- host_tx_full  out  1  TX FIFO full
- host_tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy
- host_rx_pop  in  1  consume RX FIFO head
- host_rx_data  out  8  RX FIFO head (show-ahead); valid when !host_rx_empty
- host_rx_empty  out  1  RX FIFO empty
- host_rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy
- rx_overrun  out  1  sticky: a received byte was dropped because RX FIFO was full
- rx_frame_err  out  1  sticky: transceiver reported a bad stop bit
- err_clear  in  1  clears rx_overrun and rx_frame_err
- u_tx_data  out  8  to transceiver tx_data
- u_tx_wr  out  1  to transceiver tx_wr (registered)
- u_tx_busy  in  1  from transceiver tx_busy
- u_rx_data  in  8  from transceiver rx_data
- u_rx_avail  in  1  from transceiver rx_avail
- u_rx_error  in  1  from transceiver rx_error
- u_rx_ack  out  1  to transceiver rx_ack (registered)

Behaviour:
- Reset:
  - Both FIFOs empty, so host_tx_full=0, levels=0, host_rx_empty=1.
  - u_tx_wr=0, u_tx_data=0, u_rx_ack=0, rx_overrun=0, rx_frame_err=0.
  - Both FSMs return to IDLE.
  - Reset mid-transfer discards all FIFO contents and any byte in flight; the transceiver is reset by the same signal.
- FIFOs:
  - Circular buffers with DEPTH_LOG2-bit pointers that wrap modulo 2^DEPTH_LOG2.
  - Occupancy counters are DEPTH_LOG2+1 bits wide, so a full FIFO reads 2^DEPTH_LOG2.
  - Push when full is ignored (no state change). Pop when empty is ignored.
  - Simultaneous push and pop on a non-empty, non-full FIFO: both take effect and level is unchanged.
  - Simultaneous push and pop on an empty FIFO: only the push takes effect.
  - Simultaneous push and pop on a full FIFO: both take effect.
  - Level and flags update on the clock edge after the push or pop.
- TX drain FSM, states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if TX FIFO is non-empty and u_tx_busy=0, register u_tx_data<=head and u_tx_wr<=1, pop the FIFO, go to ISSUE.
  - ISSUE: u_tx_wr<=0; go to WAIT_BUSY.
  - WAIT_BUSY: when u_tx_busy=1, go to WAIT_DONE.
  - WAIT_DONE: when u_tx_busy=0, go to IDLE.
  - u_tx_wr is exactly one cycle wide.
  - First u_tx_wr is asserted 2 cycles after the first push into an empty FIFO.
  - One byte is in flight at a time; back-to-back bytes are separated only by transceiver frame time plus 2 cycles.
- RX capture FSM, states IDLE, ACK, GUARD:
  - IDLE, u_rx_avail=1: push u_rx_data into the RX FIFO if not full; otherwise set rx_overrun and drop the byte. Assert u_rx_ack<=1 and go to ACK.
  - IDLE, u_rx_avail=0 and u_rx_error=1: set rx_frame_err, assert u_rx_ack<=1, go to ACK.
  - ACK: u_rx_ack<=0; go to GUARD.
  - GUARD: one cycle that ignores inputs while the transceiver clears its flags; then go to IDLE.
  - A single rx_avail event produces exactly one FIFO push.
  - A capture coinciding with host_rx_pop on a full FIFO is accepted, because the pop frees the slot in the same cycle.
- Error flags:
  - err_clear has priority over a same-cycle set.
  - rx_overrun and rx_frame_err stay high until err_clear or reset.

Test Plan:
- Reset, then idle 10 cycles -> host_rx_empty=1, host_tx_level=0, u_tx_wr=0, u_rx_ack=0, both error flags 0.
- Push 0x55, 0xA3, 0x0F with transceiver looped rxd<-txd -> u_tx_wr pulses three times, one cycle each, never while u_tx_busy=1. RX FIFO then pops 0x55, 0xA3, 0x0F in order; final host_rx_level=0.
- DEPTH_LOG2=2: push 6 bytes in consecutive cycles with u_tx_busy held 1 -> host_tx_level saturates at 4, host_tx_full=1, the last 2 pushes are ignored. Releasing busy transmits exactly the first 4 bytes.
- With no host pops, inject 17 received bytes at DEPTH_LOG2=4 -> host_rx_level=16, rx_overrun=1. The 17th byte is acked on u_rx_ack but absent from the FIFO. err_clear -> rx_overrun=0.
- Drive a frame with stop bit 0 -> rx_frame_err=1, u_rx_ack pulses once, RX FIFO unchanged. Assert err_clear and a second bad frame's set in the same cycle -> flag reads 0.
- RX FIFO full; pop and capture arrive in the same cycle -> level stays 16, no overrun, new byte appears last in order. Reset mid-transmit -> u_tx_wr=0, FIFOs empty next cycle.
